// File: rtl/wb_cmd_master.sv
// Wishbone B4 single-transaction command master.
// Accepts one command at a time on a valid/ready port, runs it as a
// pipelined Wishbone cycle (stall-aware), and returns read data / error /
// timeout status on a valid/ready response port.
module wb_cmd_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);

  state_t      state_q, state_d;
  logic [15:0] tmo_cnt_q;
  logic        cmd_hs, rsp_hs, tmo_expire;
  logic        bus_done, tmo_hit;

  assign cmd_hs     = cmd_valid && cmd_ready;
  assign rsp_hs     = rsp_valid && rsp_ready;
  // Counter holds cycles already spent on the bus, so expiry is the edge
  // that would complete the TIMEOUT_CYCLES-th cycle with cyc high.
  assign tmo_expire = TMO_EN && (tmo_cnt_q == TMO_LAST);

  // Next-state logic; a bus response always beats a timeout on the same edge.
  always_comb begin
    state_d  = state_q;
    bus_done = 1'b0;
    tmo_hit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_hs) state_d = REQ;
      end
      REQ: begin
        if (!wb_stall_i && (wb_ack_i || wb_err_i)) begin
          bus_done = 1'b1;
          state_d  = RESP;
        end else if (tmo_expire) begin
          tmo_hit = 1'b1;
          state_d = RESP;
        end else if (!wb_stall_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wb_ack_i || wb_err_i) begin
          bus_done = 1'b1;
          state_d  = RESP;
        end else if (tmo_expire) begin
          tmo_hit = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Handshake and bus-control outputs, registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
    end else begin
      cmd_ready <= (state_d == IDLE);
      rsp_valid <= (state_d == RESP);
      wb_cyc_o  <= (state_d == REQ) || (state_d == WAIT);
      wb_stb_o  <= (state_d == REQ);
    end
  end

  // Timeout counter: restarts per command, counts every cycle on the bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                               tmo_cnt_q <= '0;
    else if (cmd_hs)                            tmo_cnt_q <= '0;
    else if ((state_q == REQ) || (state_q == WAIT)) tmo_cnt_q <= tmo_cnt_q + 16'd1;
  end

  // Latched command drives the bus directly and stays stable while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o  <= 1'b0;
    end else if (cmd_hs) begin
      wb_adr_o <= cmd_addr;
      wb_dat_o <= cmd_wdata;
      wb_sel_o <= cmd_be;
      wb_we_o  <= cmd_we;
    end
  end

  // Response capture; error wins over ack and suppresses read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (bus_done) begin
      rsp_rdata   <= (wb_err_i || wb_we_o) ? 32'd0 : wb_dat_i;
      rsp_err     <= wb_err_i;
      rsp_timeout <= 1'b0;
    end else if (tmo_hit) begin
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b1;
    end else if (cmd_hs) begin
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: scripted Wishbone slave plus a
// response scoreboard filled when a command is issued.
module tb_wb_cmd_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_we, rsp_ready;
  logic [31:0] cmd_addr, cmd_wdata, wb_dat_i;
  logic [3:0]  cmd_be;
  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata, wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic        wb_ack_i, wb_err_i, wb_stall_i;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  wb_cmd_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_stall_i(wb_stall_i)
  );

  always #5 clk = ~clk;

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command; returns just after the accepting edge.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    logic hs;
    hs        = 1'b0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_be    = be;
    for (int i = 0; i < 20; i++) begin
      hs = cmd_ready;
      tick();
      if (hs) break;
    end
    cmd_valid = 1'b0;
    if (!hs) checkOutput("cmd_accept_bound", 0, 1);
  endtask

  // Scoreboard: compare each response at its handshake.
  always @(negedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_unexpected_rsp", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("sb_rdata", rsp_rdata, mon_e.rdata);
        checkOutput("sb_err", rsp_err, mon_e.err);
        checkOutput("sb_timeout", rsp_timeout, mon_e.tmo);
        checkOutput("sb_err_tmo_excl", rsp_err && rsp_timeout, 0);
      end
    end
  end

  initial begin
    logic [31:0] hold_rdata;
    int          cyc_cnt;
    $display("[TB] start");
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_be = '0; rsp_ready = 1'b1; wb_dat_i = '0;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_stall_i = 1'b0;

    // Reset values
    #12;
    checkOutput("rst_cyc", wb_cyc_o, 0);
    checkOutput("rst_stb", wb_stb_o, 0);
    checkOutput("rst_bus", {wb_adr_o, wb_dat_o}, 0);
    checkOutput("rst_sel_we", {wb_sel_o, wb_we_o}, 0);
    checkOutput("rst_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 0);
    checkOutput("rst_ready", cmd_ready, 0);
    tick();
    reset_n = 1'b1;
    checkOutput("ready_before_edge", cmd_ready, 0);
    tick();
    checkOutput("ready_after_edge", cmd_ready, 1);

    // Write, ack one cycle after the strobe, no WAIT state
    exp_q.push_back('{rdata: 32'h0, err: 1'b0, tmo: 1'b0});
    applyStimulus(1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
    checkOutput("wr_cyc_stb", {wb_cyc_o, wb_stb_o}, 2'b11);
    checkOutput("wr_adr", wb_adr_o, 32'h4);
    checkOutput("wr_dat", wb_dat_o, 32'hDEADBEEF);
    checkOutput("wr_sel_we", {wb_sel_o, wb_we_o}, 5'b11111);
    checkOutput("wr_ready_busy", cmd_ready, 0);
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    checkOutput("wr_rsp_valid", rsp_valid, 1);
    checkOutput("wr_bus_idle", {wb_cyc_o, wb_stb_o}, 0);
    tick();
    checkOutput("wr_back_idle", {cmd_ready, rsp_valid}, 2'b10);

    // Read with 3 stall cycles, stb held for 4 cycles with stable outputs
    exp_q.push_back('{rdata: 32'h12345678, err: 1'b0, tmo: 1'b0});
    wb_stall_i = 1'b1;
    applyStimulus(1'b0, 32'h8, 32'h0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      checkOutput("rd_stall_stb", {wb_cyc_o, wb_stb_o}, 2'b11);
      checkOutput("rd_stall_bus", {wb_adr_o, wb_sel_o, wb_we_o}, {32'h8, 4'hF, 1'b0});
      if (i < 3) tick();
    end
    wb_stall_i = 1'b0;
    wb_ack_i   = 1'b1;
    wb_dat_i   = 32'h12345678;
    tick();
    wb_ack_i = 1'b0;
    wb_dat_i = 32'h0;
    checkOutput("rd_rsp_valid", rsp_valid, 1);
    tick();

    // Write through WAIT; slave data must not leak into rsp_rdata
    exp_q.push_back('{rdata: 32'h0, err: 1'b0, tmo: 1'b0});
    applyStimulus(1'b1, 32'h20, 32'h000055AA, 4'h3);
    tick();
    checkOutput("wait_cyc_stb", {wb_cyc_o, wb_stb_o}, 2'b10);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hFFFFFFFF;
    tick();
    wb_ack_i = 1'b0;
    wb_dat_i = 32'h0;
    tick();

    // Ack and err together: error wins, data suppressed
    exp_q.push_back('{rdata: 32'h0, err: 1'b1, tmo: 1'b0});
    applyStimulus(1'b0, 32'h10, 32'h0, 4'hF);
    wb_ack_i = 1'b1;
    wb_err_i = 1'b1;
    wb_dat_i = 32'hAAAA5555;
    tick();
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = 32'h0;
    tick();

    // Timeout with silent slave, then backpressure and a late ack
    exp_q.push_back('{rdata: 32'h0, err: 1'b0, tmo: 1'b1});
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 32'h40, 32'h0, 4'hF);
    cyc_cnt = 0;
    while (wb_cyc_o && cyc_cnt < 40) begin
      cyc_cnt++;
      tick();
    end
    checkOutput("tmo_cyc_cycles", cyc_cnt, 8);
    checkOutput("tmo_flags", {rsp_valid, rsp_timeout, rsp_err}, 3'b110);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hCAFEF00D;
    tick();
    wb_ack_i = 1'b0;
    hold_rdata = rsp_rdata;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_rsp_hold", {rsp_valid, rsp_timeout, rsp_err, rsp_rdata},
                  {3'b110, 32'h0});
      checkOutput("bp_ready_bus", {cmd_ready, wb_cyc_o, wb_stb_o}, 0);
      tick();
    end
    checkOutput("bp_rdata_stable", rsp_rdata, hold_rdata);
    rsp_ready = 1'b1;
    tick();
    checkOutput("bp_released", {cmd_ready, rsp_valid}, 2'b10);

    // Spurious ack in IDLE is dropped
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    checkOutput("idle_spurious_ack", {rsp_valid, wb_cyc_o, cmd_ready}, 3'b001);

    // Reset while in WAIT abandons the cycle
    applyStimulus(1'b0, 32'h80, 32'h0, 4'hF);
    tick();
    checkOutput("pre_rst_wait", {wb_cyc_o, wb_stb_o}, 2'b10);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_async_bus", {wb_cyc_o, wb_stb_o, rsp_valid, cmd_ready}, 0);
    tick();
    reset_n = 1'b1;
    tick();
    checkOutput("rst_recover", {cmd_ready, rsp_valid, wb_cyc_o}, 3'b100);
    exp_q.push_back('{rdata: 32'h0BADC0DE, err: 1'b0, tmo: 1'b0});
    applyStimulus(1'b0, 32'hC, 32'h0, 4'hF);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h0BADC0DE;
    tick();
    wb_ack_i = 1'b0;
    wb_dat_i = 32'h0;
    checkOutput("post_rst_rsp", rsp_valid, 1);
    tick();
    tick();

    checkOutput("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, range 0..65535: maximum cycles with wb_cyc_o high before forced termination; 0 disables the timeout.
REQ-002 clk  input  1  single clock; all outputs registered on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high on an edge.
REQ-006 cmd_we / cmd_addr / cmd_wdata / cmd_be  input  1/32/32/4  write flag, byte address, write data, byte enables.
REQ-007 rsp_valid  output  1  response available.
REQ-008 rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high.
REQ-009 rsp_rdata / rsp_err / rsp_timeout  output  32/1/1  read data, bus error flag, timeout flag.
REQ-010 wb_adr_o / wb_dat_o / wb_sel_o / wb_we_o  output  32/32/4/1  Wishbone B4 master address, data, select and write-enable signals.
REQ-011 wb_cyc_o / wb_stb_o  output  1/1  Wishbone cycle and strobe.
REQ-012 wb_dat_i / wb_ack_i / wb_err_i / wb_stall_i  input  32/1/1/1  slave read data, acknowledge, error and stall.

Function
REQ-013 The FSM SHALL have the states IDLE, REQ, WAIT and RESP, with one transaction outstanding at a time.
REQ-014 IDLE SHALL be defined as: cmd_ready=1; on a command handshake, latch we/addr/wdata/be, clear the timeout counter, and go to REQ.
REQ-015 REQ SHALL be defined as: wb_cyc_o=1, wb_stb_o=1, and wb_adr_o/wb_dat_o/wb_sel_o/wb_we_o driven from the latched command.
  - When wb_stall_i=1: stay in REQ with all bus outputs held stable.
  - When wb_stall_i=0: the request is accepted; go to WAIT, and wb_stb_o=0 from the next cycle.
REQ-016 An ack or err sampled in the same cycle as the request is accepted in REQ SHALL complete the transaction directly, going to RESP and skipping WAIT.
REQ-017 WAIT SHALL be defined as: wb_cyc_o=1, wb_stb_o=0.
  - On wb_ack_i: capture wb_dat_i into rsp_rdata (reads only; rsp_rdata=0 for writes), then go to RESP.
  - On wb_err_i: set rsp_err=1, then go to RESP.
REQ-018 When wb_ack_i and wb_err_i are sampled high together, err SHALL win: rsp_err=1 and rsp_rdata=0.
REQ-019 The timeout counter SHALL increment every cycle in REQ or WAIT; when it reaches TIMEOUT_CYCLES without ack/err (TIMEOUT_CYCLES>0), set rsp_timeout=1 and go to RESP.
  - wb_cyc_o and wb_stb_o deassert on that same transition.
  - An ack/err arriving on the expiry cycle takes priority over the timeout.
REQ-020 RESP SHALL be defined as: wb_cyc_o=0, wb_stb_o=0, rsp_valid=1, with rsp_* held stable until the handshake; on the handshake go to IDLE.
REQ-021 cmd_ready SHALL be 0 in every state except IDLE.
REQ-022 wb_ack_i and wb_err_i SHALL be ignored in IDLE and RESP (late or spurious responses are dropped).
REQ-023 Latency with a non-stalling slave: command handshake at edge N -> cyc/stb high after N; ack sampled at edge N+k (k>=1) -> rsp_valid high after edge N+k.
REQ-024 Minimum back-to-back spacing SHALL be: the next command is accepted at the earliest one cycle after the response handshake.
REQ-025 In RESP, rsp_err and rsp_timeout SHALL never both be 1.

Reset
REQ-026 Asserting reset_n low SHALL, asynchronously:
  - force the FSM to IDLE and clear the timeout counter;
  - drive wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_dat_o=0, wb_sel_o=0;
  - drive rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, cmd_ready=0.
REQ-027 cmd_ready SHALL rise on the first clock edge after reset_n deasserts.
REQ-028 Reset mid-transaction SHALL abandon the cycle with no response generated.

Verification
REQ-029 Write: addr 0x0000_0004, data 0xDEAD_BEEF, be 0xF; slave acks one cycle after the strobe -> bus shows adr=4, dat=0xDEADBEEF, sel=0xF, we=1; response with rsp_err=0 and rsp_timeout=0.
REQ-030 Read: addr 0x0000_0008; slave stalls for 3 cycles, then acks with 0x1234_5678 -> stb held for 4 cycles with outputs stable; rsp_rdata=0x12345678.
REQ-031 Error: slave asserts ack and err together -> rsp_err=1, rsp_rdata=0, rsp_timeout=0.
REQ-032 Timeout: TIMEOUT_CYCLES=8, silent slave -> wb_cyc_o drops after exactly 8 cycles high; rsp_timeout=1; a late ack is ignored.
REQ-033 Backpressure: rsp_ready held low for 5 cycles -> rsp_* stable throughout, cmd_ready=0 throughout, bus idle.
REQ-034 Reset: reset_n pulsed low while in WAIT -> cyc/stb fall immediately; no rsp_valid; the next command completes normally.
